// File: rtl/regfile_pkg.sv
// Shared encodings and defaults for the parametrised register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 64;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned NRD_DEFAULT   = 2;

  // Value loaded by the post-reset sweep.
  localparam int unsigned INIT_ZERO  = 0;
  localparam int unsigned INIT_INDEX = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: blanking during init/reset, hardwired zero, then write bypass.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            blank,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] array_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] read_data
);

  // Priority mux; a discarded write to r0 never reaches the bypass because
  // the zero-register test catches addr == 0 first.
  always_comb begin
    read_data = '0;
    if (blank) begin
      read_data = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      read_data = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      read_data = wr_data;
    end else begin
      read_data = array_data;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with init sweep, optional zero register and bypass.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned NREGS     = NREGS_DEFAULT,
  parameter int unsigned NRD       = NRD_DEFAULT,
  parameter int unsigned INIT_MODE = INIT_INDEX,
  parameter int unsigned ZERO_REG  = 1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Reg_Write,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     Write_Data,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] Read_Data,
  output logic                init_busy
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

  state_t          state;
  logic [AW:0]     idx;
  logic [XLEN-1:0] mem [NREGS];

  logic            blank_c;
  logic            run_wr_c;
  logic            store_wr_c;
  logic [XLEN-1:0] init_val_c;

  // Reads are blanked while reset is held or the sweep runs; writes only in RUN.
  assign blank_c    = reset || (state == ST_INIT);
  assign run_wr_c   = Reg_Write && !reset && (state == ST_RUN);
  assign store_wr_c = run_wr_c && !((ZERO_REG != 0) && (rd == '0));
  assign init_val_c = (INIT_MODE == INIT_INDEX) ? XLEN'(idx[AW-1:0]) : '0;

  // Busy is a decode of the registered state, so it cannot glitch.
  assign init_busy = (state == ST_INIT);

  // FSM: reset restarts the sweep; INIT walks idx over every register once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          idx <= idx + (AW+1)'(1);
          if (idx == LAST_IDX) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          idx <= idx;
        end
        default: begin
          state <= ST_INIT;
          idx   <= '0;
        end
      endcase
    end
  end

  // Storage: sweep writes in INIT, normal port writes in RUN, nothing under reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[idx[AW-1:0]] <= init_val_c;
      end else if (store_wr_c) begin
        mem[rd] <= Write_Data;
      end
    end
  end

  // Independent read ports, each resolving zero/bypass on its own address.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rp (
      .blank      (blank_c),
      .addr       (rs[k*AW +: AW]),
      .array_data (mem[rs[k*AW +: AW]]),
      .wr_en      (run_wr_c),
      .wr_addr    (rd),
      .wr_data    (Write_Data),
      .read_data  (Read_Data[k*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two configurations driven in lockstep, directed
// table, sweep/reset sequences, then random traffic against a reference model.
module tb_regfile_param;

  localparam int unsigned NR = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         we;
  logic [4:0]   rd;
  logic [63:0]  wd;
  logic [14:0]  rs_a;
  logic [9:0]   rs_b;
  logic [191:0] rdata_a;
  logic [127:0] rdata_b;
  logic         busy_a;
  logic         busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: sweep flag/progress and the architectural register contents.
  bit          m_init = 1'b1;
  int          m_cnt  = 0;
  logic [63:0] mem_a [NR];
  logic [63:0] mem_b [NR];

  always #5 clk = ~clk;

  assign rs_b = rs_a[9:0];

  // A: index sweep, zero register, three read ports.
  regfile_param #(
    .XLEN(64), .NREGS(NR), .NRD(3), .INIT_MODE(1), .ZERO_REG(1)
  ) dut_a (
    .clk(clk), .reset(reset), .Reg_Write(we), .rd(rd), .Write_Data(wd),
    .rs(rs_a), .Read_Data(rdata_a), .init_busy(busy_a)
  );

  // B: zero sweep, r0 ordinary, two read ports sharing A's ports 0/1 addresses.
  regfile_param #(
    .XLEN(64), .NREGS(NR), .NRD(2), .INIT_MODE(0), .ZERO_REG(0)
  ) dut_b (
    .clk(clk), .reset(reset), .Reg_Write(we), .rd(rd), .Write_Data(wd),
    .rs(rs_b), .Read_Data(rdata_b), .init_busy(busy_b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic [4:0]  rs0, rs1, rs2;
    logic [63:0] ea0, ea1, ea2, eb0, eb1;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rs(input int unsigned a0, input int unsigned a1, input int unsigned a2);
    rs_a = {5'(a2), 5'(a1), 5'(a0)};
  endtask

  function automatic logic [63:0] exp_rd(input bit is_a, input int unsigned addr);
    if (reset || m_init) return 64'd0;
    if (is_a && addr == 0) return 64'd0;
    if (we && (int'(rd) == int'(addr))) return wd;
    return is_a ? mem_a[addr] : mem_b[addr];
  endfunction

  // What the register file should hold after the posedge with current inputs.
  task automatic model_edge();
    if (reset) begin
      m_init = 1'b1;
      m_cnt  = 0;
    end else if (m_init) begin
      m_cnt++;
      if (m_cnt == int'(NR)) begin
        m_init = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
          mem_a[i] = 64'(i);
          mem_b[i] = 64'd0;
        end
      end
    end else if (we) begin
      if (rd != 5'd0) mem_a[rd] = wd;
      mem_b[rd] = wd;
    end
  endtask

  // Compare all outputs with the model, then advance one clock.
  task automatic cycle();
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("model_a_port%0d", k), rdata_a[k*64 +: 64], exp_rd(1'b1, int'(rs_a[k*5 +: 5])));
    for (int k = 0; k < 2; k++)
      check($sformatf("model_b_port%0d", k), rdata_b[k*64 +: 64], exp_rd(1'b0, int'(rs_b[k*5 +: 5])));
    check("model_busy_a", 64'(busy_a), 64'(m_init));
    check("model_busy_b", 64'(busy_b), 64'(m_init));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Release reset and count busy cycles; optionally present a write mid-sweep.
  task automatic run_sweep(input int wr_at);
    int cnt;
    cnt   = 0;
    reset = 1'b0;
    while (busy_a === 1'b1 && cnt < 100) begin
      if (cnt == wr_at) begin
        we = 1'b1; rd = 5'd3; wd = 64'h99;
        set_rs(3, 3, 3);
        #1;
        check("init_read_zero_a", rdata_a[63:0], 64'd0);
        check("init_read_zero_b", rdata_b[63:0], 64'd0);
      end else begin
        we = 1'b0;
        set_rs($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      end
      cycle();
      cnt++;
    end
    we = 1'b0;
    check("init_busy_cycles", 64'(cnt), 64'd32);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0, 64'd0, 5'd5, 5'd31, 5'd3,
                64'd5, 64'd31, 64'd3, 64'd0, 64'd0};
    vecs[1] = '{1'b1, 5'd7, 64'hDEAD_BEEF_0000_0001, 5'd7, 5'd7, 5'd3,
                64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 64'd3,
                64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
    vecs[2] = '{1'b0, 5'd0, 64'd0, 5'd7, 5'd7, 5'd7,
                64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001,
                64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
    vecs[3] = '{1'b1, 5'd0, 64'h55, 5'd0, 5'd0, 5'd1,
                64'd0, 64'd0, 64'd1, 64'h55, 64'h55};
    vecs[4] = '{1'b0, 5'd0, 64'd0, 5'd0, 5'd1, 5'd2,
                64'd0, 64'd1, 64'd2, 64'h55, 64'd0};
    vecs[5] = '{1'b1, 5'd9, 64'h1234, 5'd9, 5'd8, 5'd9,
                64'h1234, 64'd8, 64'h1234, 64'h1234, 64'd0};
    vecs[6] = '{1'b0, 5'd0, 64'd0, 5'd9, 5'd9, 5'd9,
                64'h1234, 64'h1234, 64'h1234, 64'h1234, 64'h1234};

    reset = 1'b1; we = 1'b0; rd = '0; wd = '0; rs_a = '0;

    // Reset held three cycles; state is unknown until the first sampled edge.
    @(negedge clk);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("reset_busy_a", 64'(busy_a), 64'd1);
    check("reset_read_a", rdata_a[63:0], 64'd0);
    cycle();
    cycle();

    // First sweep, with a write attempt during its tenth cycle that must be dropped.
    run_sweep(10);

    // Directed RUN-phase vectors with hand-computed results.
    foreach (vecs[i]) begin
      we = vecs[i].we; rd = vecs[i].rd; wd = vecs[i].wd;
      set_rs(vecs[i].rs0, vecs[i].rs1, vecs[i].rs2);
      #1;
      check($sformatf("vec%0d_a0", i), rdata_a[63:0],    vecs[i].ea0);
      check($sformatf("vec%0d_a1", i), rdata_a[127:64],  vecs[i].ea1);
      check($sformatf("vec%0d_a2", i), rdata_a[191:128], vecs[i].ea2);
      check($sformatf("vec%0d_b0", i), rdata_b[63:0],    vecs[i].eb0);
      check($sformatf("vec%0d_b1", i), rdata_b[127:64],  vecs[i].eb1);
      cycle();
    end
    we = 1'b0;

    // One-cycle reset pulse in RUN with a write presented: write dropped, sweep restarts.
    reset = 1'b1; we = 1'b1; rd = 5'd12; wd = 64'hABCD;
    set_rs(12, 9, 12);
    cycle();
    we = 1'b0;
    check("pulse_busy_a", 64'(busy_a), 64'd1);
    run_sweep(-1);

    set_rs(9, 9, 9);
    #1;
    check("post_reset_r9_a0", rdata_a[63:0],    64'd9);
    check("post_reset_r9_a1", rdata_a[127:64],  64'd9);
    check("post_reset_r9_a2", rdata_a[191:128], 64'd9);
    check("post_reset_r9_b0", rdata_b[63:0],    64'd0);
    cycle();
    set_rs(12, 3, 0);
    #1;
    check("post_reset_r12_a", rdata_a[63:0],   64'd12);
    check("post_reset_r3_a",  rdata_a[127:64], 64'd3);
    cycle();

    // Random traffic with occasional resets, checked against the model.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      we    = $urandom_range(0, 1) == 1;
      rd    = 5'($urandom_range(0, 31));
      wd    = {$urandom, $urandom};
      set_rs($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) rs_a[4:0] = rd;
      if ($urandom_range(0, 7) == 0) rs_a[9:5] = 5'd0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
